// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces two push-buttons and two
// 4-bit switch banks.
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   key        : raw push-buttons (active-high, asynchronous)
//   in_number  : raw operand switches
//   arif       : raw operation-select switches
//   key_pulse  : one-cycle press strobe per key, never both bits together
//   key_level  : debounced key state
//   number_out : debounced in_number
//   arif_out   : debounced arif

// Per-key press/release debouncer. The press strobe is combinational and is
// registered by the parent so that both keys can be serialized there.
module ic_key_fsm #(
  parameter int DEBOUNCE_N = 50000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_s,
  output logic level,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_N - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, PRESS_CNT, PRESSED, RELEASE_CNT} st_t;

  st_t              st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             lvl_n;

  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      level <= lvl_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    lvl_n = level;
    press = 1'b0;
    case (st)
      IDLE: if (key_s) begin
        st_n  = PRESS_CNT;
        cnt_n = '0;
      end
      PRESS_CNT:
        if (!key_s) st_n = IDLE;
        else if (cnt == LAST) begin
          st_n  = PRESSED;
          lvl_n = 1'b1;
          press = 1'b1;
        end else cnt_n = cnt_inc;
      PRESSED: if (!key_s) begin
        st_n  = RELEASE_CNT;
        cnt_n = '0;
      end
      RELEASE_CNT:
        if (key_s) st_n = PRESSED;
        else if (cnt == LAST) begin
          st_n  = IDLE;
          lvl_n = 1'b0;
        end else cnt_n = cnt_inc;
      default: st_n = IDLE;
    endcase
  end
endmodule

// Multi-bit debouncer: a candidate value must stay unchanged for DEBOUNCE_N
// cycles before it is copied to q. A candidate equal to q does not count.
module ic_bus_debounce #(
  parameter int DEBOUNCE_N = 50000,
  parameter int CNT_W      = 16,
  parameter int W          = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_N - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
      q    <= '0;
    end else if (d != cand) begin
      cand <= d;
      cnt  <= '0;
    end else if (cand == q) begin
      cnt  <= '0;
    end else if (cnt == LAST) begin
      q    <= cand;
      cnt  <= '0;
    end else if (cnt != CMAX) begin
      cnt  <= cnt + CNT_W'(1);
    end
  end
endmodule

module input_conditioner #(
  parameter int DEBOUNCE_N = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key,
  input  logic [3:0] in_number,
  input  logic [3:0] arif,
  output logic [1:0] key_pulse,
  output logic [1:0] key_level,
  output logic [3:0] number_out,
  output logic [3:0] arif_out
);
  localparam int NUM_KEYS = 2;

  logic [9:0]          sync1, sync2;
  logic [NUM_KEYS-1:0] key_s, press_ev;
  logic                pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {arif, in_number, key};
      sync2 <= sync1;
    end
  end

  assign key_s = sync2[1:0];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    ic_key_fsm #(.DEBOUNCE_N(DEBOUNCE_N), .CNT_W(CNT_W)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_s (key_s[g]),
      .level (key_level[g]),
      .press (press_ev[g])
    );
  end

  ic_bus_debounce #(.DEBOUNCE_N(DEBOUNCE_N), .CNT_W(CNT_W), .W(4)) u_num (
    .clk (clk), .rst_n (rst_n), .d (sync2[5:2]), .q (number_out)
  );

  ic_bus_debounce #(.DEBOUNCE_N(DEBOUNCE_N), .CNT_W(CNT_W), .W(4)) u_arif (
    .clk (clk), .rst_n (rst_n), .d (sync2[9:6]), .q (arif_out)
  );

  // key[1] wins a collision; key[0] waits one cycle in pend. A key[0] event
  // that lands while pend is already set merges into the pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pulse <= '0;
      pend      <= 1'b0;
    end else if (press_ev[1]) begin
      key_pulse <= 2'b10;
      pend      <= pend | press_ev[0];
    end else if (pend || press_ev[0]) begin
      key_pulse <= 2'b01;
      pend      <= 1'b0;
    end else begin
      key_pulse <= 2'b00;
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key = '0;
  logic [3:0] in_number = '0;
  logic [3:0] arif = '0;
  logic [1:0] key_pulse, key_level;
  logic [3:0] number_out, arif_out;

  int n_cmp = 0;
  int n_bad = 0;

  input_conditioner #(.DEBOUNCE_N(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .in_number  (in_number),
    .arif       (arif),
    .key_pulse  (key_pulse),
    .key_level  (key_level),
    .number_out (number_out),
    .arif_out   (arif_out)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then sample just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] ep;
    key = 2'b11; in_number = 4'hF; arif = 4'h3;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({key_pulse, key_level, number_out, arif_out} !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d: got %h, want 000", i,
                 {key_pulse, key_level, number_out, arif_out});
      end
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      ep = (e == 6) ? 2'b10 : (e == 7) ? 2'b01 : 2'b00;
      n_cmp++;
      if (key_pulse !== ep) begin
        n_bad++;
        $display("FAIL reset_release_pulse e%0d: got %b, want %b", e, key_pulse, ep);
      end
      if (e == 5 || e == 6) begin
        n_cmp++;
        if ({key_level, number_out, arif_out} !== ((e == 6) ? 10'h3F3 : 10'h000)) begin
          n_bad++;
          $display("FAIL reset_release_levels e%0d: got %h", e,
                   {key_level, number_out, arif_out});
        end
      end
    end
    key = 2'b00; in_number = 4'h0; arif = 4'h0;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if ({key_level, number_out, arif_out} !== 10'h000) begin
      n_bad++;
      $display("FAIL reset_settle: got %h, want 000", {key_level, number_out, arif_out});
    end
  endtask

  task automatic test_single_press();
    logic [1:0] ep, el;
    key = 2'b01;
    for (int e = 0; e < 20; e++) begin
      step();
      ep = (e == 6) ? 2'b01 : 2'b00;
      el = (e >= 6) ? 2'b01 : 2'b00;
      n_cmp++;
      if (key_pulse !== ep || key_level !== el) begin
        n_bad++;
        $display("FAIL single_press e%0d: pulse %b lvl %b, want %b %b", e, key_pulse, key_level, ep, el);
      end
    end
    key = 2'b00;
    for (int e = 0; e < 10; e++) begin
      step();
      el = (e < 6) ? 2'b01 : 2'b00;
      n_cmp++;
      if (key_pulse !== 2'b00 || key_level !== el) begin
        n_bad++;
        $display("FAIL single_release e%0d: pulse %b lvl %b, want 00 %b", e, key_pulse, key_level, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] ep;
    int npulse = 0;
    for (int e = 0; e < 16; e++) begin
      key = ((e < 3) || (e >= 4 && e < 14)) ? 2'b01 : 2'b00;
      step();
      if (key_pulse != 2'b00) npulse++;
      ep = (e == 10) ? 2'b01 : 2'b00;
      n_cmp++;
      if (key_pulse !== ep) begin
        n_bad++;
        $display("FAIL bounce e%0d: got %b, want %b", e, key_pulse, ep);
      end
    end
    n_cmp++;
    if (npulse != 1) begin
      n_bad++;
      $display("FAIL bounce_count: got %0d pulses, want 1", npulse);
    end
    key = 2'b00;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("FAIL bounce_release: lvl %b, want 00", key_level);
    end
  endtask

  task automatic test_both_keys();
    logic [1:0] ep;
    key = 2'b11;
    for (int e = 0; e <= 10; e++) begin
      step();
      ep = (e == 6) ? 2'b10 : (e == 7) ? 2'b01 : 2'b00;
      n_cmp++;
      if (key_pulse !== ep) begin
        n_bad++;
        $display("FAIL both_keys e%0d: got %b, want %b", e, key_pulse, ep);
      end
    end
    key = 2'b00;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (key_level !== 2'b00) begin
      n_bad++;
      $display("FAIL both_release: lvl %b, want 00", key_level);
    end
  endtask

  task automatic test_bus();
    logic [3:0] en, ea;
    in_number = 4'h5;
    for (int e = 0; e <= 8; e++) begin
      step();
      en = (e >= 6) ? 4'h5 : 4'h0;
      n_cmp++;
      if (number_out !== en) begin
        n_bad++;
        $display("FAIL bus_settle e%0d: got %h, want %h", e, number_out, en);
      end
    end
    in_number = 4'h7;
    step();
    step();
    in_number = 4'h5;
    for (int e = 0; e < 10; e++) begin
      step();
      n_cmp++;
      if (number_out !== 4'h5) begin
        n_bad++;
        $display("FAIL bus_glitch e%0d: got %h, want 5", e, number_out);
      end
    end
    arif = 4'hA;
    for (int e = 0; e <= 7; e++) begin
      step();
      ea = (e >= 6) ? 4'hA : 4'h0;
      n_cmp++;
      if (arif_out !== ea || number_out !== 4'h5) begin
        n_bad++;
        $display("FAIL arif_settle e%0d: arif %h num %h, want %h 5", e, arif_out, number_out, ea);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ep;
    key = 2'b10;
    for (int e = 0; e <= 4; e++) step();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({key_pulse, key_level, number_out, arif_out} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_async: got %h, want 000", {key_pulse, key_level, number_out, arif_out});
    end
    key = 2'b00; in_number = 4'h0; arif = 4'h0;
    step();
    step();
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      n_cmp++;
      if (key_pulse !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_discard e%0d: got %b, want 00", e, key_pulse);
      end
    end
    key = 2'b10;
    for (int e = 0; e <= 7; e++) begin
      step();
      ep = (e == 6) ? 2'b10 : 2'b00;
      n_cmp++;
      if (key_pulse !== ep) begin
        n_bad++;
        $display("FAIL repress e%0d: got %b, want %b", e, key_pulse, ep);
      end
    end
    key = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_both_keys();
    test_bus();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_N, default 50000, meaning cycles an input must hold stable to be accepted (legal range 2 to 2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of every stability counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port key  input  2  raw push-buttons, active-high, asynchronous to clk.
REQ-006 SHALL have port in_number  input  4  raw operand switches, asynchronous.
REQ-007 SHALL have port arif  input  4  raw operation-select switches, asynchronous.
REQ-008 SHALL have port key_pulse  output  2  registered one-cycle press strobe per key, never both bits high together.
REQ-009 SHALL have port key_level  output  2  registered debounced key state.
REQ-010 SHALL have port number_out  output  4  registered debounced in_number.
REQ-011 SHALL have port arif_out  output  4  registered debounced arif.

Function
REQ-012 SHALL pass every bit of key, in_number and arif through a 2-flop synchronizer before any other logic uses it.
REQ-013 SHALL run one independent 4-state FSM per key: IDLE, PRESS_CNT, PRESSED, RELEASE_CNT.
REQ-014 IDLE: synced key 1 -> PRESS_CNT, counter cleared to 0; otherwise stay.
REQ-015 PRESS_CNT: synced 0 -> IDLE; synced 1 and counter = DEBOUNCE_N-1 -> PRESSED, key_level bit set, press event raised; otherwise counter +1.
REQ-016 PRESSED: synced 0 -> RELEASE_CNT, counter cleared; otherwise stay.
REQ-017 RELEASE_CNT: synced 1 -> PRESSED; synced 0 and counter = DEBOUNCE_N-1 -> IDLE, key_level bit cleared; otherwise counter +1; release raises no pulse.
REQ-018 Latency: with edge 0 the first edge sampling raw key high and key held high, key_pulse and key_level SHALL assert at edge DEBOUNCE_N+2; release latency SHALL equal DEBOUNCE_N+2 likewise.
REQ-019 key_pulse bit SHALL be high for exactly one cycle per accepted press, regardless of hold duration.
REQ-020 Simultaneous press events on the same edge: key_pulse SHALL be 2'b10 on that edge and 2'b01 on the next edge via a one-deep pending flag for key[0].
REQ-021 A key[0] press event arriving while its pending flag is set SHALL be merged (one pulse only).
REQ-022 number_out SHALL update to the synced in_number only after that value is unchanged for DEBOUNCE_N consecutive cycles; any change restarts the count from 0.
REQ-023 arif_out SHALL follow the same rule as REQ-022 with its own counter.
REQ-024 Counters SHALL saturate, never wrap; a value already equal to the output SHALL not restart counting needlessly (output unchanged).

Reset
REQ-025 rst_n low SHALL immediately force all FSMs to IDLE, all counters, synchronizers, pending flag and outputs to 0, independent of clk.
REQ-026 Reset release with a key already held SHALL be treated as a new press (pulse at edge DEBOUNCE_N+2 after release).
REQ-027 Reset asserted during PRESS_CNT or while pending SHALL discard the event; no pulse after reset.

Verification (DEBOUNCE_N=4)
REQ-028 rst_n=0, key=11, in_number=F, arif=3 -> all outputs 0 for entire reset, no pulse at release edge.
REQ-029 key[0] high from edge 0, held 20 cycles -> key_pulse=01 only at edge 6, key_level[0]=1 from edge 6; release -> key_level[0]=0 six edges later, no pulse.
REQ-030 key[0] high 3 cycles, low 1, high 10 -> exactly one pulse, at edge 6 counted from the second rise.
REQ-031 both keys rise at edge 0 -> key_pulse=10 at edge 6, 01 at edge 7, 00 afterwards.
REQ-032 in_number 0->5 held -> number_out=5 at edge 6; then 5->7 for 2 cycles and back to 5 -> number_out stays 5.
REQ-033 rst_n pulsed low at edge 4 of a key[1] press -> outputs 0 asynchronously, no key_pulse produced before re-press.
